// File: rtl/nios_position_slew.sv
// Multi-channel slew-limited position output on an Avalon-MM slave.
// Each channel steps CURRENT toward TARGET by STEP on every prescaler tick and flags arrival.
module nios_position_slew #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 12,
    parameter int TICK_DIV   = 50000,
    parameter int RESET_STEP = 1,
    parameter int ADDR_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [CHANNELS*WIDTH-1:0] out_port,
    output logic                      irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Distance is formed one bit wider so the step comparison never wraps.
    function automatic logic [WIDTH:0] distance(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt);
        if (tgt > cur) return {1'b0, tgt} - {1'b0, cur};
        else           return {1'b0, cur} - {1'b0, tgt};
    endfunction

    function automatic logic [WIDTH-1:0] slew_next(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] stp);
        if (distance(cur, tgt) <= {1'b0, stp}) return tgt;
        else if (tgt > cur)                    return cur + stp;
        else                                   return cur - stp;
    endfunction

    function automatic logic [31:0] reg_word(input logic [1:0] sel, input logic [WIDTH-1:0] tgt,
                                             input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] stp,
                                             input logic done, input logic ie);
        logic [31:0] word;
        word = 32'd0;
        case (sel)
            2'd0:    word[WIDTH-1:0] = tgt;
            2'd1:    word[WIDTH-1:0] = cur;
            2'd2:    word[WIDTH-1:0] = stp;
            2'd3:    word[2:0]       = {ie, done, (cur != tgt)};
            default: word            = 32'd0;
        endcase
        return word;
    endfunction

    logic [PW-1:0]       presc_r;
    logic                tick_s;
    logic                wr_s;
    logic [ADDR_W-1:0]   chan_s;
    logic [1:0]          reg_s;
    logic [WIDTH-1:0]    target_r  [CHANNELS];
    logic [WIDTH-1:0]    current_r [CHANNELS];
    logic [WIDTH-1:0]    step_r    [CHANNELS];
    logic [CHANNELS-1:0] done_r;
    logic [CHANNELS-1:0] ie_r;
    logic [CHANNELS-1:0] sel_s;
    logic [CHANNELS-1:0] snap_s;
    logic [CHANNELS-1:0] clr_s;
    logic [CHANNELS-1:0] move_s;
    logic [CHANNELS-1:0] arrive_s;
    logic                unused_ok_s;

    assign wr_s        = chipselect & ~write_n;
    assign chan_s      = address >> 2'd2;
    assign reg_s       = address[1:0];
    assign tick_s      = (presc_r == PW'(TICK_DIV - 1));
    assign unused_ok_s = &{1'b0, writedata};

    // Per-channel write decode and motion qualification for this cycle.
    always_comb begin
        sel_s    = '0;
        snap_s   = '0;
        clr_s    = '0;
        move_s   = '0;
        arrive_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sel_s[c]    = wr_s && (chan_s == ADDR_W'(c));
            snap_s[c]   = sel_s[c] && (reg_s == 2'd3) && writedata[3];
            clr_s[c]    = sel_s[c] && (reg_s == 2'd3) && writedata[1];
            move_s[c]   = tick_s && (step_r[c] != '0) && (current_r[c] != target_r[c]) && !snap_s[c];
            arrive_s[c] = move_s[c] && (distance(current_r[c], target_r[c]) <= {1'b0, step_r[c]});
        end
    end

    // Prescaler and per-channel register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
            done_r  <= '0;
            ie_r    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                target_r[c]  <= '0;
                current_r[c] <= '0;
                step_r[c]    <= WIDTH'(RESET_STEP);
            end
        end else begin
            if (tick_s) presc_r <= '0;
            else        presc_r <= presc_r + PW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                if (sel_s[c] && (reg_s == 2'd0)) target_r[c] <= writedata[WIDTH-1:0];
                if (sel_s[c] && (reg_s == 2'd2)) step_r[c]   <= writedata[WIDTH-1:0];
                if (sel_s[c] && (reg_s == 2'd3)) ie_r[c]     <= writedata[2];
                // SNAP overrides any concurrent tick and leaves DONE alone.
                if (snap_s[c])      current_r[c] <= target_r[c];
                else if (move_s[c]) current_r[c] <= slew_next(current_r[c], target_r[c], step_r[c]);
                if (arrive_s[c])    done_r[c] <= 1'b1;
                else if (clr_s[c])  done_r[c] <= 1'b0;
            end
        end
    end

    // Zero-wait read mux; unmatched channel indices fall through to zero.
    always_comb begin
        readdata = 32'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            readdata = readdata | ((chan_s == ADDR_W'(c)) ?
                       reg_word(reg_s, target_r[c], current_r[c], step_r[c], done_r[c], ie_r[c]) : 32'd0);
        end
    end

    // Position bus packing and interrupt reduction.
    always_comb begin
        out_port = '0;
        irq      = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_port[c*WIDTH +: WIDTH] = current_r[c];
            irq = irq | (done_r[c] & ie_r[c]);
        end
    end

endmodule

// File: tb/tb_nios_position_slew.sv
// Randomised and directed checks of nios_position_slew against a behavioural model
// (3 channels so that channel index 3 is out of range, TICK_DIV=4).
module tb_nios_position_slew;

    localparam int NCH = 3;
    localparam int W   = 12;
    localparam int TD  = 4;
    localparam int AW  = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [AW-1:0]    address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'd0;
    logic [31:0]      readdata;
    logic [NCH*W-1:0] out_port;
    logic             irq;

    int checks = 0;
    int failures = 0;

    int m_tgt [NCH];
    int m_cur [NCH];
    int m_stp [NCH];
    bit m_done[NCH];
    bit m_ie  [NCH];
    int mcount;

    always #5 clk = ~clk;

    nios_position_slew #(.CHANNELS(NCH), .WIDTH(W), .TICK_DIV(TD), .RESET_STEP(1), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .out_port(out_port), .irq(irq)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [AW-1:0] addr_of(input int ch, input int r);
        return AW'(ch * 4 + r);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_tgt[c] = 0; m_cur[c] = 0; m_stp[c] = 1; m_done[c] = 0; m_ie[c] = 0;
        end
        mcount = 0;
    endtask

    // Advance the model across one clock edge using the bus inputs presented now.
    task automatic model_apply();
        int ch, r, d, ad;
        bit wr, tick, arrive;
        ch   = int'(address[3:2]);
        r    = int'(address[1:0]);
        wr   = chipselect && !write_n && (ch < NCH);
        tick = (mcount == TD - 1);
        mcount = tick ? 0 : mcount + 1;
        for (int c = 0; c < NCH; c++) begin
            arrive = 0;
            if (wr && ch == c && r == 3 && writedata[3]) begin
                m_cur[c] = m_tgt[c];
            end else if (tick && m_stp[c] != 0 && m_cur[c] != m_tgt[c]) begin
                d  = m_tgt[c] - m_cur[c];
                ad = (d < 0) ? -d : d;
                if (ad <= m_stp[c]) begin
                    m_cur[c] = m_tgt[c];
                    arrive = 1;
                end else begin
                    m_cur[c] = m_cur[c] + ((d > 0) ? m_stp[c] : -m_stp[c]);
                end
            end
            if (arrive) m_done[c] = 1;
            else if (wr && ch == c && r == 3 && writedata[1]) m_done[c] = 0;
            if (wr && ch == c) begin
                case (r)
                    0: m_tgt[c] = int'(writedata[W-1:0]);
                    2: m_stp[c] = int'(writedata[W-1:0]);
                    3: m_ie[c]  = writedata[2];
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [NCH*W-1:0] model_out();
        logic [NCH*W-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*W +: W] = W'(m_cur[c]);
        return v;
    endfunction

    function automatic logic model_irq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < NCH; c++) v = v | (m_done[c] & m_ie[c]);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int ch, r;
        ch = int'(a[3:2]);
        r  = int'(a[1:0]);
        if (ch >= NCH) return 32'd0;
        case (r)
            0: return 32'(m_tgt[ch]);
            1: return 32'(m_cur[ch]);
            2: return 32'(m_stp[ch]);
            default: return {29'd0, m_ie[ch], m_done[ch], (m_cur[ch] != m_tgt[ch])};
        endcase
    endfunction

    task automatic step_cycle();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step_cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        step_cycle();
        chipselect = 1'b0;
    endtask

    task automatic wait_tick_cycle();
        for (int i = 0; i < TD + 1; i++) begin
            if (mcount == TD - 1) break;
            step_cycle();
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        checks++;
        if (out_port !== '0) begin failures++; $display("FAIL reset_out got=%0h exp=0", out_port); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        for (int c = 0; c < NCH; c++) begin
            bus_read(addr_of(c, 2), got);
            checks++;
            if (got !== 32'd1) begin failures++; $display("FAIL reset_step ch%0d got=%0d exp=1", c, got); end
            bus_read(addr_of(c, 3), got);
            checks++;
            if (got !== 32'd0) begin failures++; $display("FAIL reset_ctrl ch%0d got=%0d exp=0", c, got); end
        end
    endtask

    task automatic test_slew();
        int seen[$];
        int v, prev;
        logic [31:0] got;
        bus_write(addr_of(1, 2), 32'd100);
        bus_write(addr_of(1, 0), 32'd250);
        prev = 0;
        for (int i = 0; i < 30; i++) begin
            step_cycle();
            checks++;
            if (out_port !== model_out()) begin failures++; $display("FAIL slew_out got=%0h exp=%0h", out_port, model_out()); end
            v = int'(out_port[W +: W]);
            if (v != prev) seen.push_back(v);
            prev = v;
        end
        checks++;
        if (seen.size() != 3 || seen[0] != 100 || seen[1] != 200 || seen[2] != 250) begin
            failures++; $display("FAIL slew_sequence got=%p exp='{100,200,250}", seen);
        end
        bus_read(addr_of(1, 3), got);
        checks++;
        if (got !== 32'd2) begin failures++; $display("FAIL slew_done got=%0d exp=2", got); end
        checks++;
        if (out_port[0 +: W] !== 12'd0 || out_port[2*W +: W] !== 12'd0) begin
            failures++; $display("FAIL slew_others got=%0h exp=0 on ch0/ch2", out_port);
        end
    endtask

    task automatic test_down();
        int seen[$];
        int v, prev;
        logic [31:0] got;
        bus_write(addr_of(1, 3), 32'h2);
        bus_write(addr_of(1, 2), 32'd300);
        bus_write(addr_of(1, 0), 32'd0);
        prev = 250;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            v = int'(out_port[W +: W]);
            if (v != prev) seen.push_back(v);
            prev = v;
        end
        checks++;
        if (seen.size() != 1 || seen[0] != 0) begin failures++; $display("FAIL down_sequence got=%p exp='{0}", seen); end
        bus_read(addr_of(1, 3), got);
        checks++;
        if (got !== 32'd2) begin failures++; $display("FAIL down_done got=%0d exp=2", got); end
    endtask

    task automatic test_irq();
        int ticks, rise_ticks;
        bit rose;
        logic [31:0] got;
        bus_write(addr_of(2, 3), 32'h4);
        bus_write(addr_of(2, 2), 32'd1);
        bus_write(addr_of(2, 0), 32'd5);
        ticks = 0; rose = 0; rise_ticks = -1;
        for (int i = 0; i < 40 && !rose; i++) begin
            if (mcount == TD - 1) ticks++;
            step_cycle();
            checks++;
            if (irq !== model_irq()) begin failures++; $display("FAIL irq_track got=%0b exp=%0b", irq, model_irq()); end
            if (irq === 1'b1) begin rose = 1; rise_ticks = ticks; end
        end
        checks++;
        if (rise_ticks != 5) begin failures++; $display("FAIL irq_rise_ticks got=%0d exp=5", rise_ticks); end
        bus_write(addr_of(2, 3), 32'h2);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%0b exp=0", irq); end
        bus_read(addr_of(2, 3), got);
        checks++;
        if (got !== 32'd0) begin failures++; $display("FAIL irq_ctrl_cleared got=%0d exp=0", got); end
        bus_write(addr_of(2, 3), 32'h4);
        bus_write(addr_of(2, 0), 32'd7);
        for (int i = 0; i < 20; i++) begin
            if (mcount == TD - 1 && m_cur[2] != m_tgt[2] && (m_tgt[2] - m_cur[2]) <= m_stp[2]) break;
            step_cycle();
        end
        bus_write(addr_of(2, 3), 32'h6);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%0b exp=1", irq); end
        bus_read(addr_of(2, 3), got);
        checks++;
        if (got !== 32'd6) begin failures++; $display("FAIL set_wins_ctrl got=%0d exp=6", got); end
    endtask

    task automatic test_snap();
        logic [31:0] got;
        bus_write(addr_of(0, 2), 32'd0);
        bus_write(addr_of(0, 0), 32'd4095);
        idle(40);
        checks++;
        if (out_port[0 +: W] !== 12'd0) begin failures++; $display("FAIL freeze_hold got=%0d exp=0", out_port[0 +: W]); end
        bus_read(addr_of(0, 3), got);
        checks++;
        if (got !== 32'd1) begin failures++; $display("FAIL freeze_busy got=%0d exp=1", got); end
        bus_write(addr_of(0, 3), 32'h8);
        checks++;
        if (out_port[0 +: W] !== 12'd4095) begin failures++; $display("FAIL snap_value got=%0d exp=4095", out_port[0 +: W]); end
        bus_read(addr_of(0, 3), got);
        checks++;
        if (got !== 32'd0) begin failures++; $display("FAIL snap_ctrl got=%0d exp=0", got); end
    endtask

    task automatic test_addressing();
        logic [31:0] got;
        int prev;
        bus_write(addr_of(3, 0), 32'd123);
        bus_write(addr_of(3, 3), 32'hF);
        for (int r = 0; r < 4; r++) begin
            bus_read(addr_of(3, r), got);
            checks++;
            if (got !== 32'd0) begin failures++; $display("FAIL oob_read reg%0d got=%0d exp=0", r, got); end
        end
        checks++;
        if (out_port !== model_out() || irq !== model_irq()) begin
            failures++; $display("FAIL oob_side_effect got=%0h/%0b exp=%0h/%0b", out_port, irq, model_out(), model_irq());
        end
        bus_write(addr_of(0, 1), 32'd77);
        bus_read(addr_of(0, 1), got);
        checks++;
        if (got !== 32'd4095) begin failures++; $display("FAIL current_ro got=%0d exp=4095", got); end
        bus_write(addr_of(1, 2), 32'd10);
        bus_write(addr_of(1, 0), 32'd100);
        for (int i = 0; i < 20 && m_cur[1] == 0; i++) step_cycle();
        wait_tick_cycle();
        prev = m_cur[1];
        bus_write(addr_of(1, 0), 32'd0);
        checks++;
        if (out_port[W +: W] !== 12'(prev + 10)) begin
            failures++; $display("FAIL target_tick_old got=%0d exp=%0d", out_port[W +: W], prev + 10);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        bus_write(addr_of(0, 2), 32'd1);
        bus_write(addr_of(0, 0), 32'd1000);
        idle(8);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== '0 || irq !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0h/%0b exp=0/0", out_port, irq); end
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < NCH; c++) begin
            bus_read(addr_of(c, 2), got);
            checks++;
            if (got !== 32'd1) begin failures++; $display("FAIL mid_reset_step ch%0d got=%0d exp=1", c, got); end
            bus_read(addr_of(c, 3), got);
            checks++;
            if (got !== 32'd0) begin failures++; $display("FAIL mid_reset_ctrl ch%0d got=%0d exp=0", c, got); end
        end
        idle(12);
        checks++;
        if (out_port !== '0) begin failures++; $display("FAIL mid_reset_hold got=%0h exp=0", out_port); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [31:0] d, got, exp;
        int op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 3);
            a  = AW'($urandom_range(0, 15));
            if (op == 0) begin
                step_cycle();
            end else if (op == 1) begin
                exp = model_read(a);
                bus_read(a, got);
                checks++;
                if (got !== exp) begin failures++; $display("FAIL rand_read addr=%0d got=%0h exp=%0h", a, got, exp); end
            end else begin
                case (a[1:0])
                    2'd2:    d = 32'($urandom_range(0, 700));
                    2'd3:    d = 32'($urandom_range(0, 15));
                    default: d = $urandom();
                endcase
                bus_write(a, d);
            end
            checks++;
            if (out_port !== model_out() || irq !== model_irq()) begin
                failures++; $display("FAIL rand_state got=%0h/%0b exp=%0h/%0b", out_port, irq, model_out(), model_irq());
            end
        end
    endtask

    initial begin
        model_reset();
        #22 reset_n = 1'b1;
        test_reset();
        test_slew();
        test_down();
        test_irq();
        test_snap();
        test_addressing();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_position_slew.md
# nios_position_slew

Parametrised successor to the single-channel position output port. Exposes CHANNELS independent WIDTH-bit position outputs on one Avalon-MM slave. Each channel's output is slew-limited: it steps toward a software-written target by a programmable amount on every prescaler tick. An arrival interrupt lets the Nios write a target and return, instead of bit-banging intermediate positions.

## Interface
- CHANNELS, 4, number of position channels (1..16)
- WIDTH, 12, bits per position value (1..31)
- TICK_DIV, 50000, clock cycles per motion tick (≥1; 1 = tick every cycle)
- RESET_STEP, 1, per-channel STEP value after reset
- ADDR_W, 4, address width; must equal clog2(CHANNELS)+2
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address: {channel, reg[1:0]}
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero-wait-state (combinational from registers)
- out_port  out  CHANNELS*WIDTH  current positions; channel c at [c*WIDTH +: WIDTH]
- irq  out  1  OR over channels of (DONE & IE)

## Operation
- Write strobe is chipselect & ~write_n. Reads have no side effects.
- Per-channel registers, selected by reg = address[1:0]:
  - 0 TARGET (RW): writedata[WIDTH-1:0].
  - 1 CURRENT (RO): present output value. Writes are ignored.
  - 2 STEP (RW): writedata[WIDTH-1:0]. STEP=0 freezes the channel. CURRENT holds and DONE is never set by motion.
  - 3 CTRL/STATUS:
    - bit0 BUSY (RO) = CURRENT≠TARGET.
    - bit1 DONE (write 1 to clear).
    - bit2 IE (RW).
    - bit3 SNAP (write-only, reads 0). Writing 1 copies TARGET to CURRENT on that edge. SNAP does not set DONE.
- Channel index ≥ CHANNELS: writes are ignored, reads return 0.
- All read fields are zero-extended to 32 bits.
- Prescaler: counter counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle the count equals TICK_DIV-1.
- On each tick, for every channel with STEP≠0 and CURRENT≠TARGET:
  - If |TARGET−CURRENT| ≤ STEP: CURRENT←TARGET and DONE←1.
  - Otherwise CURRENT moves by STEP toward TARGET.
- Arithmetic is unsigned WIDTH-bit. The difference and comparison use WIDTH+1 bits, so CURRENT never overshoots or wraps.
- Simultaneous events:
  - TARGET write and tick in the same cycle: the tick uses the old TARGET. The new TARGET is registered on the same edge.
  - STEP write and tick in the same cycle: the tick uses the old STEP.
  - DONE clear and DONE set in the same cycle: set wins.
  - SNAP and tick in the same cycle: SNAP wins, using the TARGET value before the edge.
  - Combined TARGET write and SNAP: not possible. They are different registers, so this takes two writes.
- Reset values (asynchronous, all registers): TARGET=0, CURRENT=0, STEP=RESET_STEP, DONE=0, IE=0, prescaler=0. Consequently out_port=0, irq=0, readdata reflects these.
- Reset asserted mid-motion aborts immediately to the reset values. Motion resumes only after new TARGET writes.

## Timing
- Register writes take effect on the clk edge where the strobe is sampled.
- readdata is valid in the same cycle as address/chipselect.
- out_port is a direct register output, updating on the tick edge.
- DONE is set on the tick edge of arrival. irq rises combinationally from the registered DONE/IE, so it is visible in the cycle after that edge.
- irq deasserts in the cycle after the DONE-clear write edge, or after the IE←0 write edge.
- Worst-case moves to reach the target = ceil(|Δ| / STEP) ticks. The first move occurs at the first tick strictly after the TARGET write edge.
- The prescaler free-runs. It is not restarted by register writes.

## Test plan
- **Reset:** CHANNELS=4, WIDTH=12. Assert reset_n=0 mid-motion → out_port=0, irq=0. Read STEP → 1 and CTRL → 0 on every channel.
- **Slew:** TICK_DIV=4. Write ch1 STEP=100, TARGET=250 → ch1 CURRENT reads 100, 200, 250 on successive ticks (every 4 clk). DONE is set at 250; ch0, ch2 and ch3 stay 0.
- **Downward, no wrap:** CURRENT=250, STEP=300, TARGET=0 → one tick gives 0 with DONE=1 (no underflow to 0xFxx).
- **IRQ:** IE=1 on ch2, TARGET=5, STEP=1 → irq rises one cycle after the 5th tick. Write CTRL=0x2 → irq low the next cycle. Clear and set in the same cycle → DONE stays 1.
- **SNAP / freeze:**
  - STEP=0, TARGET=4095 → CURRENT holds across 10 ticks and BUSY=1.
  - Write CTRL bit3 → CURRENT=4095, DONE=0, BUSY=0.
- **Addressing:** CHANNELS=3, access channel 3 → reads 0 and writes have no effect. A CURRENT write is ignored. A TARGET write coinciding with a tick → the move uses the old target.
